// File: rtl/sweep_generator_pkg.sv
// Shared types and constants for the NCO sweep generator.
package sweep_generator_pkg;

  // Sweep sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } SWEEP_STATE;

  // Bit indices into the mode field
  localparam int unsigned MODE_TRIANGLE = 0;
  localparam int unsigned MODE_SINGLE   = 1;
  localparam int unsigned MODE_WIDTH    = 2;

endpackage

// File: rtl/sweep_dwell_counter.sv
// Enable-gated dwell counter; fires a terminal-count pulse once count reaches the limit.
module sweep_dwell_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             ipClk,
  input  logic             Reset,
  input  logic             ipClear,
  input  logic             ipEnable,
  input  logic [WIDTH-1:0] ipLimit,
  output logic             opTerminal_c
);

  logic [WIDTH-1:0] count;

  // Terminal count is seen on the enabled tick that would otherwise overrun the limit
  assign opTerminal_c = ipEnable && !ipClear && (count >= ipLimit);

  // Count enabled ticks, wrapping to zero on terminal count
  always_ff @(posedge ipClk) begin
    if (Reset || ipClear) begin
      count <= '0;
    end else if (ipEnable) begin
      count <= opTerminal_c ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/sweep_generator.sv
// Stepped frequency-word generator for the NCO: sawtooth/triangle, continuous/single-shot.
module sweep_generator
  import sweep_generator_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DWELL_WIDTH = 16
) (
  input  logic                   ipClk,
  input  logic                   ipReset,
  input  logic                   ipClkEnable,
  input  logic                   ipStart,
  input  logic                   ipAbort,
  input  logic [MODE_WIDTH-1:0]  ipMode,
  input  logic [WIDTH-1:0]       ipFreqStart,
  input  logic [WIDTH-1:0]       ipFreqStop,
  input  logic [WIDTH-1:0]       ipFreqStep,
  input  logic [DWELL_WIDTH-1:0] ipDwell,
  output logic [WIDTH-1:0]       opFrequency,
  output logic                   opTrigger,
  output logic                   opBusy,
  output logic                   opDone,
  output logic                   opError
);

  // Snapshot of the configuration taken on an accepted start
  typedef struct packed {
    logic [MODE_WIDTH-1:0]  mode;
    logic [WIDTH-1:0]       start;
    logic [WIDTH-1:0]       stop;
    logic [WIDTH-1:0]       step;
    logic [DWELL_WIDTH-1:0] dwell;
  } SWEEP_CONFIG;

  logic        Reset;
  SWEEP_STATE  state;
  SWEEP_CONFIG cfg;

  logic             configValid_c;
  logic             startAccept_c;
  logic             startReject_c;
  logic             dwellClear_c;
  logic             dwellEnable_c;
  logic             stepTick_c;
  logic             cycleEnd_c;
  logic [WIDTH:0]   upSum_c;
  logic [WIDTH:0]   downDiff_c;
  logic [WIDTH-1:0] upNext_c;
  logic [WIDTH-1:0] downNext_c;

  // Reset request is registered once before use
  always_ff @(posedge ipClk) begin
    Reset <= ipReset;
  end

  // Start qualification and dwell counter control
  always_comb begin
    configValid_c = (ipFreqStart < ipFreqStop) && (ipFreqStep != '0);
    startAccept_c = ipStart && !ipAbort && configValid_c;
    startReject_c = ipStart && !ipAbort && !configValid_c;
    dwellClear_c  = ipAbort || startAccept_c || (state == IDLE);
    dwellEnable_c = ipClkEnable && (state != IDLE);
  end

  sweep_dwell_counter #(
    .WIDTH(DWELL_WIDTH)
  ) uDwell (
    .ipClk       (ipClk),
    .Reset       (Reset),
    .ipClear     (dwellClear_c),
    .ipEnable    (dwellEnable_c),
    .ipLimit     (cfg.dwell),
    .opTerminal_c(stepTick_c)
  );

  // Saturating next-step values and end-of-cycle detection
  always_comb begin
    upSum_c    = {1'b0, opFrequency} + {1'b0, cfg.step};
    downDiff_c = {1'b0, opFrequency} - {1'b0, cfg.step};
    upNext_c   = (upSum_c >= {1'b0, cfg.stop}) ? cfg.stop : upSum_c[WIDTH-1:0];
    downNext_c = (downDiff_c[WIDTH] || (downDiff_c[WIDTH-1:0] <= cfg.start))
                 ? cfg.start : downDiff_c[WIDTH-1:0];
    cycleEnd_c = 1'b0;
    if (stepTick_c) begin
      if ((state == UP) && (opFrequency >= cfg.stop) && !cfg.mode[MODE_TRIANGLE]) begin
        cycleEnd_c = 1'b1;
      end
      if ((state == DOWN) && (opFrequency <= cfg.start)) begin
        cycleEnd_c = 1'b1;
      end
    end
  end

  // Sweep sequencer with registered outputs
  always_ff @(posedge ipClk) begin
    if (Reset) begin
      state       <= IDLE;
      cfg         <= '0;
      opFrequency <= '0;
      opTrigger   <= 1'b0;
      opBusy      <= 1'b0;
      opDone      <= 1'b0;
      opError     <= 1'b0;
    end else begin
      opTrigger <= 1'b0;
      opDone    <= 1'b0;
      if (ipAbort) begin
        state  <= IDLE;
        opBusy <= 1'b0;
      end else if (startAccept_c) begin
        cfg         <= '{mode: ipMode, start: ipFreqStart, stop: ipFreqStop,
                         step: ipFreqStep, dwell: ipDwell};
        opFrequency <= ipFreqStart;
        opTrigger   <= 1'b1;
        opBusy      <= 1'b1;
        opError     <= 1'b0;
        state       <= UP;
      end else begin
        if (startReject_c) begin
          opError <= 1'b1;
        end
        if (cycleEnd_c) begin
          if (cfg.mode[MODE_SINGLE]) begin
            state  <= IDLE;
            opBusy <= 1'b0;
            opDone <= 1'b1;
          end else begin
            opFrequency <= cfg.start;
            opTrigger   <= 1'b1;
            state       <= UP;
          end
        end else if (stepTick_c) begin
          case (state)
            UP: begin
              if (opFrequency < cfg.stop) begin
                opFrequency <= upNext_c;
              end else begin
                // Triangle turns around at the top and steps down on the same tick
                state       <= DOWN;
                opFrequency <= downNext_c;
              end
            end
            DOWN:    opFrequency <= downNext_c;
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sweep_generator.sv
// Directed self-checking bench for sweep_generator (8-bit frequency word).
module tb_sweep_generator;

  localparam int unsigned W  = 8;
  localparam int unsigned DW = 16;

  logic          ipClk = 1'b0;
  logic          ipReset;
  logic          ipClkEnable;
  logic          ipStart;
  logic          ipAbort;
  logic [1:0]    ipMode;
  logic [W-1:0]  ipFreqStart;
  logic [W-1:0]  ipFreqStop;
  logic [W-1:0]  ipFreqStep;
  logic [DW-1:0] ipDwell;
  logic [W-1:0]  opFrequency;
  logic          opTrigger;
  logic          opBusy;
  logic          opDone;
  logic          opError;

  int nChecks = 0;
  int nFails  = 0;

  sweep_generator #(.WIDTH(W), .DWELL_WIDTH(DW)) dut (
    .ipClk      (ipClk),
    .ipReset    (ipReset),
    .ipClkEnable(ipClkEnable),
    .ipStart    (ipStart),
    .ipAbort    (ipAbort),
    .ipMode     (ipMode),
    .ipFreqStart(ipFreqStart),
    .ipFreqStop (ipFreqStop),
    .ipFreqStep (ipFreqStep),
    .ipDwell    (ipDwell),
    .opFrequency(opFrequency),
    .opTrigger  (opTrigger),
    .opBusy     (opBusy),
    .opDone     (opDone),
    .opError    (opError)
  );

  // Clock generation
  always #5 ipClk = ~ipClk;

  task automatic tick();
    @(posedge ipClk);
    #1;
  endtask

  task automatic pulseStart(input logic [1:0] m, input logic [W-1:0] s, input logic [W-1:0] p,
                            input logic [W-1:0] st, input logic [DW-1:0] d);
    ipMode      = m;
    ipFreqStart = s;
    ipFreqStop  = p;
    ipFreqStep  = st;
    ipDwell     = d;
    ipStart     = 1'b1;
    tick();
    ipStart = 1'b0;
  endtask

  task automatic pulseAbort();
    ipAbort = 1'b1;
    tick();
    ipAbort = 1'b0;
  endtask

  task automatic test_reset();
    ipReset = 1'b1; ipClkEnable = 1'b0; ipStart = 1'b0; ipAbort = 1'b0;
    ipMode = '0; ipFreqStart = '0; ipFreqStop = '0; ipFreqStep = '0; ipDwell = '0;
    repeat (3) tick();
    nChecks++; if (opFrequency !== 8'h00) begin nFails++; $display("FAIL reset_freq: got %0h expected 0", opFrequency); end
    nChecks++; if (opTrigger !== 1'b0) begin nFails++; $display("FAIL reset_trigger: got %b expected 0", opTrigger); end
    nChecks++; if (opBusy !== 1'b0) begin nFails++; $display("FAIL reset_busy: got %b expected 0", opBusy); end
    nChecks++; if (opDone !== 1'b0) begin nFails++; $display("FAIL reset_done: got %b expected 0", opDone); end
    nChecks++; if (opError !== 1'b0) begin nFails++; $display("FAIL reset_error: got %b expected 0", opError); end
    ipReset = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_saw_continuous();
    int expF[6] = '{10, 20, 30, 40, 10, 20};
    logic expT[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    ipClkEnable = 1'b1;
    pulseStart(2'b00, 8'd10, 8'd40, 8'd10, 16'd0);
    ipFreqStart = 8'd99;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      nChecks++; if (opFrequency !== W'(expF[i])) begin nFails++; $display("FAIL saw_freq[%0d]: got %0d expected %0d", i, opFrequency, expF[i]); end
      nChecks++; if (opTrigger !== expT[i]) begin nFails++; $display("FAIL saw_trigger[%0d]: got %b expected %b", i, opTrigger, expT[i]); end
      nChecks++; if (opBusy !== 1'b1) begin nFails++; $display("FAIL saw_busy[%0d]: got %b expected 1", i, opBusy); end
    end
    pulseAbort();
    nChecks++; if (opBusy !== 1'b0) begin nFails++; $display("FAIL saw_abort_busy: got %b expected 0", opBusy); end
    nChecks++; if (opFrequency !== 8'd20) begin nFails++; $display("FAIL saw_abort_freq: got %0d expected 20", opFrequency); end
  endtask

  task automatic test_triangle_single();
    int vals[7] = '{10, 20, 30, 40, 30, 20, 10};
    ipClkEnable = 1'b1;
    pulseStart(2'b11, 8'd10, 8'd40, 8'd10, 16'd2);
    for (int i = 0; i < 21; i++) begin
      if (i > 0) tick();
      nChecks++; if (opFrequency !== W'(vals[i/3])) begin nFails++; $display("FAIL tri_freq[%0d]: got %0d expected %0d", i, opFrequency, vals[i/3]); end
      nChecks++; if ({opBusy, opDone} !== 2'b10) begin nFails++; $display("FAIL tri_busy_done[%0d]: got %b expected 10", i, {opBusy, opDone}); end
    end
    tick();
    nChecks++; if ({opBusy, opDone} !== 2'b01) begin nFails++; $display("FAIL tri_end_busy_done: got %b expected 01", {opBusy, opDone}); end
    nChecks++; if (opFrequency !== 8'd10) begin nFails++; $display("FAIL tri_end_freq: got %0d expected 10", opFrequency); end
    tick();
    nChecks++; if (opDone !== 1'b0) begin nFails++; $display("FAIL tri_done_width: got %b expected 0", opDone); end
    nChecks++; if (opFrequency !== 8'd10) begin nFails++; $display("FAIL tri_hold_freq: got %0d expected 10", opFrequency); end
  endtask

  task automatic test_saturation();
    ipClkEnable = 1'b1;
    pulseStart(2'b10, 8'hF0, 8'hFF, 8'h20, 16'd0);
    nChecks++; if (opFrequency !== 8'hF0) begin nFails++; $display("FAIL sat_up_0: got %0h expected f0", opFrequency); end
    tick();
    nChecks++; if (opFrequency !== 8'hFF) begin nFails++; $display("FAIL sat_up_1: got %0h expected ff", opFrequency); end
    tick();
    nChecks++; if ({opFrequency, opDone} !== {8'hFF, 1'b1}) begin nFails++; $display("FAIL sat_up_done: got %0h/%b expected ff/1", opFrequency, opDone); end
    pulseStart(2'b11, 8'h05, 8'h10, 8'h20, 16'd0);
    nChecks++; if (opFrequency !== 8'h05) begin nFails++; $display("FAIL sat_dn_0: got %0h expected 05", opFrequency); end
    tick();
    nChecks++; if (opFrequency !== 8'h10) begin nFails++; $display("FAIL sat_dn_1: got %0h expected 10", opFrequency); end
    tick();
    nChecks++; if ({opFrequency, opBusy} !== {8'h05, 1'b1}) begin nFails++; $display("FAIL sat_dn_2: got %0h/%b expected 05/1", opFrequency, opBusy); end
    tick();
    nChecks++; if ({opFrequency, opDone} !== {8'h05, 1'b1}) begin nFails++; $display("FAIL sat_dn_done: got %0h/%b expected 05/1", opFrequency, opDone); end
  endtask

  task automatic test_bad_config();
    ipClkEnable = 1'b1;
    pulseStart(2'b00, 8'd50, 8'd50, 8'd10, 16'd0);
    nChecks++; if ({opError, opBusy} !== 2'b10) begin nFails++; $display("FAIL bad_equal: got err/busy %b expected 10", {opError, opBusy}); end
    tick();
    nChecks++; if (opError !== 1'b1) begin nFails++; $display("FAIL bad_sticky: got %b expected 1", opError); end
    pulseStart(2'b00, 8'd10, 8'd40, 8'd0, 16'd0);
    nChecks++; if ({opError, opBusy} !== 2'b10) begin nFails++; $display("FAIL bad_step0: got err/busy %b expected 10", {opError, opBusy}); end
    pulseStart(2'b00, 8'd10, 8'd40, 8'd10, 16'd0);
    nChecks++; if ({opError, opBusy, opTrigger} !== 3'b011) begin nFails++; $display("FAIL bad_clear: got err/busy/trig %b expected 011", {opError, opBusy, opTrigger}); end
    nChecks++; if (opFrequency !== 8'd10) begin nFails++; $display("FAIL bad_clear_freq: got %0d expected 10", opFrequency); end
    pulseAbort();
  endtask

  task automatic test_start_abort();
    ipClkEnable = 1'b1;
    pulseStart(2'b00, 8'd10, 8'd40, 8'd10, 16'd0);
    tick();
    ipFreqStart = 8'd5; ipStart = 1'b1; ipAbort = 1'b1;
    tick();
    ipStart = 1'b0; ipAbort = 1'b0;
    nChecks++; if ({opBusy, opTrigger} !== 2'b00) begin nFails++; $display("FAIL both_busy_trig: got %b expected 00", {opBusy, opTrigger}); end
    nChecks++; if (opFrequency !== 8'd20) begin nFails++; $display("FAIL both_freq: got %0d expected 20", opFrequency); end
    tick();
    nChecks++; if (opFrequency !== 8'd20) begin nFails++; $display("FAIL both_hold: got %0d expected 20", opFrequency); end
    pulseStart(2'b00, 8'd10, 8'd40, 8'd10, 16'd0);
    tick();
    pulseStart(2'b00, 8'd15, 8'd40, 8'd5, 16'd0);
    nChecks++; if ({opFrequency, opTrigger, opBusy} !== {8'd15, 1'b1, 1'b1}) begin nFails++; $display("FAIL restart: got %0d/%b/%b expected 15/1/1", opFrequency, opTrigger, opBusy); end
    tick();
    nChecks++; if ({opFrequency, opTrigger} !== {8'd20, 1'b0}) begin nFails++; $display("FAIL restart_step: got %0d/%b expected 20/0", opFrequency, opTrigger); end
    pulseAbort();
  endtask

  task automatic test_enable_and_reset();
    int expF[13] = '{10, 10, 10, 20, 20, 20, 20, 30, 30, 30, 30, 10, 10};
    ipClkEnable = 1'b0;
    pulseStart(2'b00, 8'd10, 8'd30, 8'd10, 16'd0);
    nChecks++; if ({opFrequency, opTrigger} !== {8'd10, 1'b1}) begin nFails++; $display("FAIL en_start: got %0d/%b expected 10/1", opFrequency, opTrigger); end
    for (int c = 0; c < 13; c++) begin
      ipClkEnable = ((c % 4) == 3);
      tick();
      nChecks++; if (opFrequency !== W'(expF[c])) begin nFails++; $display("FAIL en_freq[%0d]: got %0d expected %0d", c, opFrequency, expF[c]); end
      nChecks++; if (opTrigger !== (c == 11)) begin nFails++; $display("FAIL en_trigger[%0d]: got %b expected %b", c, opTrigger, c == 11); end
    end
    ipClkEnable = 1'b1;
    ipReset = 1'b1;
    tick();
    nChecks++; if (opBusy !== 1'b1) begin nFails++; $display("FAIL rst_latency_busy: got %b expected 1", opBusy); end
    tick();
    nChecks++; if ({opFrequency, opTrigger, opBusy, opDone, opError} !== 12'h000) begin nFails++; $display("FAIL rst_mid_sweep: got %0h/%b/%b/%b/%b expected all 0", opFrequency, opTrigger, opBusy, opDone, opError); end
    ipReset = 1'b0;
    tick();
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_saw_continuous();
    test_triangle_single();
    test_saturation();
    test_bad_config();
    test_start_abort();
    test_enable_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
